lfsr_crc_checker: RTL and testbench

//  Receive-side partner of the serial LFSR CRC generator. Consumes the generator's

---
 rtl/lfsr_crc_checker.sv | 178 +++++++++++++++++
 tb/tb_lfsr_crc_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_crc_checker.sv
// lfsr_crc_checker
// Receive-side partner of the serial LFSR CRC generator. Runs the same LFSR over
// the incoming payload bits, then compares the serially received CRC bits
// (LSB first) against the LFSR contents, reporting a per-frame verdict plus a
// saturating count of failed or aborted frames.

module lfsr_crc_checker #(
    parameter int             N     = 8,
    parameter logic [N-1:0]   TAPS  = 8'b01000100,
    parameter logic [N-1:0]   SEED  = 8'hD8,
    parameter int             CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Data,
    input  logic             ACTIVE,
    input  logic             CRC,
    input  logic             Valid,
    output logic             Busy,
    output logic             Done,
    output logic             Pass,
    output logic             Abort,
    output logic [CNT_W-1:0] Err_Count
);

    // Wide enough to hold values 0..N so the check-bit index never wraps.
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_CHECK
    } state_t;

    state_t           state_q,    state_d;
    logic [N-1:0]     lfsr_q,     lfsr_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic             mismatch_q, mismatch_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             pass_q,     pass_d;
    logic             abort_q,    abort_d;
    logic [CNT_W-1:0] err_q,      err_d;

    // Per-cycle qualifiers derived from the inputs and current state.
    logic             in_check;
    logic             do_step;
    logic             do_check;
    logic [CW-1:0]    eff_cnt;
    logic             eff_mismatch;
    logic             bit_mismatch;
    logic             last_bit;
    logic             abort_evt;
    logic             verdict_evt;
    logic             verdict_pass;
    logic             frame_fail;

    // LFSR next-value helpers.
    logic             feedback;
    logic [N-1:0]     step_val;
    logic [N-1:0]     shift_val;

    // Decode what kind of cycle this is; ACTIVE always takes priority over Valid,
    // and a check step taken on the CHECK entry edge sees cleared count/mismatch.
    always_comb begin
        in_check     = (state_q == ST_CHECK);
        do_step      = ACTIVE;
        do_check     = Valid & ~ACTIVE;
        eff_cnt      = in_check ? cnt_q : '0;
        eff_mismatch = in_check & mismatch_q;
        bit_mismatch = CRC ^ lfsr_q[0];
        last_bit     = (eff_cnt == CW'(N - 1));
        abort_evt    = ACTIVE & in_check;
        verdict_evt  = do_check & last_bit;
        verdict_pass = ~(eff_mismatch | bit_mismatch);
        frame_fail   = abort_evt | (verdict_evt & ~verdict_pass);
    end

    // Generator-identical LFSR step on Data, and the zero-filling drain shift.
    always_comb begin
        feedback = lfsr_q[0] ^ Data;
        step_val = '0;
        for (int i = 0; i < N - 1; i++) begin
            step_val[i] = lfsr_q[i+1] ^ (TAPS[i] & feedback);
        end
        step_val[N-1] = feedback;
        shift_val     = lfsr_q >> 1;
    end

    // LFSR update: payload cycles step, check cycles drain, everything else holds.
    always_comb begin
        lfsr_d = lfsr_q;
        if (do_step) begin
            lfsr_d = step_val;
        end else if (do_check) begin
            lfsr_d = shift_val;
        end
    end

    // State transitions, check-bit counter and running mismatch flag.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mismatch_d = mismatch_q;
        if (ACTIVE) begin
            state_d    = ST_DATA;
            cnt_d      = '0;
            mismatch_d = 1'b0;
        end else if (Valid) begin
            if (last_bit) begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                mismatch_d = 1'b0;
            end else begin
                state_d    = ST_CHECK;
                cnt_d      = eff_cnt + CW'(1);
                mismatch_d = eff_mismatch | bit_mismatch;
            end
        end
    end

    // Verdict outputs: Done pulses for one cycle, Pass/Abort hold until the next Done.
    always_comb begin
        done_d  = 1'b0;
        pass_d  = pass_q;
        abort_d = abort_q;
        if (abort_evt) begin
            done_d  = 1'b1;
            pass_d  = 1'b0;
            abort_d = 1'b1;
        end else if (verdict_evt) begin
            done_d  = 1'b1;
            pass_d  = verdict_pass;
            abort_d = 1'b0;
        end
    end

    // Saturating failure counter and the Busy flag that tracks the next state.
    always_comb begin
        err_d = err_q;
        if (frame_fail && (err_q != {CNT_W{1'b1}})) begin
            err_d = err_q + CNT_W'(1);
        end
        busy_d = (state_d != ST_IDLE);
    end

    // All registered state; reset discards any partial frame without a verdict.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            lfsr_q     <= SEED;
            cnt_q      <= '0;
            mismatch_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            abort_q    <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            mismatch_q <= mismatch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            abort_q    <= abort_d;
            err_q      <= err_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Pass      = pass_q;
    assign Abort     = abort_q;
    assign Err_Count = err_q;

endmodule

// File: tb/tb_lfsr_crc_checker.sv
// tb_lfsr_crc_checker
// Drives directed frames and randomized frames into lfsr_crc_checker and compares
// every cycle against a frame-level model: the expected CRC is captured when the
// CRC phase starts and the received bits are assembled into a word for comparison.

module tb_lfsr_crc_checker;

    localparam int       N    = 8;
    localparam logic [7:0] TAPS = 8'b01000100;
    localparam logic [7:0] SEED = 8'hD8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Data;
    logic       ACTIVE;
    logic       CRC;
    logic       Valid;
    logic       Busy;
    logic       Done;
    logic       Pass;
    logic       Abort;
    logic [7:0] Err_Count;

    int checks     = 0;
    int failures   = 0;
    int done_seen  = 0;

    // Frame-level reference state.
    logic [7:0] m_lfsr;
    logic [7:0] m_crc_exp;
    logic [7:0] m_rx;
    int         m_k;
    int         m_phase;
    logic       m_busy;
    logic       m_done;
    logic       m_pass;
    logic       m_abort;
    logic [7:0] m_err;

    lfsr_crc_checker #(
        .N(N), .TAPS(TAPS), .SEED(SEED), .CNT_W(8)
    ) dut (
        .CLK(CLK), .RST(RST), .Data(Data), .ACTIVE(ACTIVE), .CRC(CRC),
        .Valid(Valid), .Busy(Busy), .Done(Done), .Pass(Pass), .Abort(Abort),
        .Err_Count(Err_Count)
    );

    always #5 CLK = ~CLK;

    // Polynomial form of the generator step: shift right, and when the feedback
    // bit is 1 xor in the tap mask with the top bit forced on.
    function automatic logic [7:0] genStep(input logic [7:0] l, input logic d);
        logic fb;
        fb = l[0] ^ d;
        genStep = (l >> 1) ^ (fb ? (8'h80 | (TAPS & 8'h7F)) : 8'h00);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: advances once per clock edge, clears on reset.
    initial begin
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                m_lfsr = SEED; m_crc_exp = 8'h00; m_rx = 8'h00; m_k = 0; m_phase = 0;
                m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_abort = 1'b0; m_err = 8'h00;
            end else begin
                m_done = 1'b0;
                if (ACTIVE) begin
                    if (m_phase == 2) begin
                        m_done = 1'b1; m_pass = 1'b0; m_abort = 1'b1;
                        if (m_err != 8'hFF) m_err = m_err + 8'd1;
                        m_lfsr = m_crc_exp >> m_k;
                    end
                    m_lfsr  = genStep(m_lfsr, Data);
                    m_phase = 1;
                end else if (Valid) begin
                    if (m_phase != 2) begin
                        m_phase = 2; m_crc_exp = m_lfsr; m_k = 0; m_rx = 8'h00;
                    end
                    m_rx[m_k] = CRC;
                    m_k++;
                    if (m_k == N) begin
                        m_done = 1'b1; m_pass = (m_rx == m_crc_exp); m_abort = 1'b0;
                        if (!m_pass && m_err != 8'hFF) m_err = m_err + 8'd1;
                        m_phase = 0;
                        m_lfsr  = 8'h00;
                    end
                end
                m_busy = (m_phase != 0);
            end
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge CLK);
            checkOutput("cyc_busy",  Busy,      m_busy);
            checkOutput("cyc_done",  Done,      m_done);
            checkOutput("cyc_pass",  Pass,      m_pass);
            checkOutput("cyc_abort", Abort,     m_abort);
            checkOutput("cyc_err",   Err_Count, m_err);
            if (Done === 1'b1) done_seen++;
        end
    end

    task automatic applyStimulus(input logic act, input logic d, input logic val, input logic c);
        ACTIVE = act; Data = d; Valid = val; CRC = c;
        @(posedge CLK);
        #2;
        ACTIVE = 1'b0; Data = 1'b0; Valid = 1'b0; CRC = 1'b0;
    endtask

    task automatic doReset();
        RST = 1'b1;
        @(posedge CLK);
        #2;
        RST = 1'b0;
    endtask

    task automatic sendZeros(input int n, input int gaps);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gaps; g++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic sendCrc(input logic [7:0] c, input int nbits, input int gaps);
        for (int i = 0; i < nbits; i++) begin
            for (int g = 0; g < gaps; g++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b1, c[i]);
        end
    endtask

    task automatic randomFrame();
        int         plen;
        int         abort_at;
        logic [7:0] crcv;
        plen = int'($urandom_range(0, 12));
        for (int p = 0; p < plen; p++) begin
            case ($urandom_range(0, 7))
                0:       applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
                1:       applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
                default: applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            endcase
        end
        crcv = m_lfsr;
        if ($urandom_range(0, 2) == 0) crcv = crcv ^ 8'($urandom_range(1, 255));
        abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : 8;
        for (int i = 0; i < 8; i++) begin
            if (i == abort_at) begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                break;
            end
            if ($urandom_range(0, 4) == 0) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b1, crcv[i]);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int d0;
        RST = 1'b0; ACTIVE = 1'b0; Data = 1'b0; Valid = 1'b0; CRC = 1'b0;
        #1 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;

        checkOutput("reset_busy", Busy, 1'b0);
        checkOutput("reset_pass", Pass, 1'b0);
        checkOutput("reset_err",  Err_Count, 8'd0);

        // T1: eight zero payload bits from the seed give CRC 0x14.
        sendZeros(8, 0);
        checkOutput("t1_model_crc", m_lfsr, 8'h14);
        checkOutput("t1_busy_data", Busy, 1'b1);
        sendCrc(8'h14, 8, 0);
        checkOutput("t1_done",  Done, 1'b1);
        checkOutput("t1_pass",  Pass, 1'b1);
        checkOutput("t1_abort", Abort, 1'b0);
        checkOutput("t1_err",   Err_Count, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_done_clear", Done, 1'b0);
        checkOutput("t1_idle_busy",  Busy, 1'b0);

        // T2: no reseed, LFSR drained to zero so the CRC is all zeros.
        sendZeros(8, 0);
        sendCrc(8'h00, 8, 0);
        checkOutput("t2_pass", Pass, 1'b1);
        checkOutput("t2_done", Done, 1'b1);

        // T3: corrupted CRC bit 0.
        doReset();
        sendZeros(8, 0);
        sendCrc(8'h15, 8, 0);
        checkOutput("t3_done", Done, 1'b1);
        checkOutput("t3_pass", Pass, 1'b0);
        checkOutput("t3_err",  Err_Count, 8'd1);

        // T4: payload resumes after three CRC bits.
        doReset();
        sendZeros(8, 0);
        sendCrc(8'h14, 3, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_done",  Done, 1'b1);
        checkOutput("t4_pass",  Pass, 1'b0);
        checkOutput("t4_abort", Abort, 1'b1);
        checkOutput("t4_err",   Err_Count, 8'd1);
        checkOutput("t4_busy",  Busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_abort_held", Abort, 1'b1);
        checkOutput("t4_busy_held",  Busy, 1'b1);

        // T5: gaps in both phases do not disturb the frame.
        doReset();
        d0 = done_seen;
        sendZeros(8, 2);
        sendCrc(8'h14, 8, 2);
        checkOutput("t5_pass", Pass, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_done_count", done_seen - d0, 1);

        // T6: asynchronous reset mid-CHECK.
        doReset();
        sendZeros(8, 0);
        sendCrc(8'h14, 4, 0);
        d0 = done_seen;
        #1 RST = 1'b1;
        #1;
        checkOutput("t6_busy_async", Busy, 1'b0);
        checkOutput("t6_done_async", Done, 1'b0);
        checkOutput("t6_err_async",  Err_Count, 8'd0);
        @(posedge CLK);
        #2 RST = 1'b0;
        checkOutput("t6_no_done", done_seen - d0, 0);
        sendZeros(8, 0);
        sendCrc(8'h14, 8, 0);
        checkOutput("t6_t1_pass", Pass, 1'b1);

        // Saturation: zero-length frames against a drained LFSR, all-ones CRC fails.
        for (int f = 0; f < 255; f++) sendCrc(8'hFF, 8, 0);
        checkOutput("sat_255", Err_Count, 8'd255);
        sendCrc(8'hFF, 8, 0);
        checkOutput("sat_done", Done, 1'b1);
        checkOutput("sat_hold", Err_Count, 8'd255);

        // Randomized frames with gaps, corruptions, aborts and overlapping qualifiers.
        doReset();
        for (int f = 0; f < 80; f++) randomFrame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
